// File: rtl/sec_tick_go_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : sec_tick_go_gen_if
//  Purpose  : Bundles the run/start inputs and the timebase/go outputs of
//             sec_tick_go_gen.
//  Signals  : enable     - prescaler run enable (driven by master)
//             go_raw     - raw pushbutton, asynchronous (driven by master)
//             tick       - one-cycle seconds strobe (driven by slave)
//             sec_count  - wrapping tick count since go/reset (slave)
//             go         - one-cycle accepted-press pulse (slave)
//             go_level   - debounced button level (slave)
//  Revision : 1.0  initial release
// ============================================================================
interface sec_tick_go_gen_if;
   logic       enable;
   logic       go_raw;
   logic       tick;
   logic [7:0] sec_count;
   logic       go;
   logic       go_level;

   // Side that drives the controls and consumes the timebase
   modport master (
      output enable,
      output go_raw,
      input  tick,
      input  sec_count,
      input  go,
      input  go_level
   );

   // The timebase / debounce block itself
   modport slave (
      input  enable,
      input  go_raw,
      output tick,
      output sec_count,
      output go,
      output go_level
   );
endinterface
`default_nettype wire

// File: rtl/sec_tick_go_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sec_tick_go_gen
//  Purpose  : Seconds timebase plus start-button front end. Divides clk into
//             a one-cycle tick every CLK_DIV enabled cycles with a wrapping
//             8-bit seconds count, and turns a bouncy asynchronous button
//             into a clean one-cycle go pulse and a debounced level. An
//             accepted press realigns the timebase to a fresh period.
//  Ports    : clk   - system clock (rising edge)
//             reset - synchronous, active-high reset
//             bus   - sec_tick_go_gen_if.slave (enable, go_raw in;
//                     tick, sec_count, go, go_level out)
//  Revision : 1.0  initial release
// ============================================================================
module sec_tick_go_gen #(
   parameter int CLK_DIV   = 50000000,
   parameter int DIV_W     = 26,
   parameter int DB_CYCLES = 16,
   parameter int DB_W      = 5
) (
   input  wire logic          clk,
   input  wire logic          reset,
   sec_tick_go_gen_if.slave   bus
);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
   localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } db_state_t;

   db_state_t        state;
   logic             s1;
   logic             s2;
   logic [DB_W-1:0]  db_cnt;
   logic [DIV_W-1:0] div_cnt;
   logic             tick_q;
   logic [7:0]       sec_q;
   logic             go_q;
   logic             level_q;
   logic             go_set;

   // High on exactly the edge that sets the go register; the prescaler uses
   // it to restart the period on that same edge.
   assign go_set = (state == PRESS_CHK) && s2 && (db_cnt == DB_LAST);

   // Two-flop synchroniser for the asynchronous button
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= bus.go_raw;
         s2 <= s1;
      end
   end

   // Debounce FSM: a change is accepted only after DB_CYCLES consecutive
   // identical samples of s2; any shorter excursion returns to the origin.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RELEASED;
         db_cnt  <= '0;
         go_q    <= 1'b0;
         level_q <= 1'b0;
      end else begin
         go_q <= 1'b0;
         case (state)
            RELEASED: begin
               if (s2) begin
                  state  <= PRESS_CHK;
                  db_cnt <= DB_ONE;
               end
            end
            PRESS_CHK: begin
               if (!s2) begin
                  state  <= RELEASED;
                  db_cnt <= '0;
               end else if (db_cnt == DB_LAST) begin
                  state   <= PRESSED;
                  go_q    <= 1'b1;
                  level_q <= 1'b1;
                  db_cnt  <= '0;
               end else begin
                  db_cnt <= db_cnt + DB_ONE;
               end
            end
            PRESSED: begin
               if (!s2) begin
                  state  <= RELEASE_CHK;
                  db_cnt <= DB_ONE;
               end
            end
            RELEASE_CHK: begin
               if (s2) begin
                  state  <= PRESSED;
                  db_cnt <= '0;
               end else if (db_cnt == DB_LAST) begin
                  state   <= RELEASED;
                  level_q <= 1'b0;
                  db_cnt  <= '0;
               end else begin
                  db_cnt <= db_cnt + DB_ONE;
               end
            end
            default: begin
               state  <= RELEASED;
               db_cnt <= '0;
            end
         endcase
      end
   end

   // Prescaler and seconds counter. A go realignment takes priority over a
   // coinciding terminal count, so that edge produces no tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
         tick_q  <= 1'b0;
         sec_q   <= 8'd0;
      end else begin
         tick_q <= 1'b0;
         if (go_set) begin
            div_cnt <= '0;
            sec_q   <= 8'd0;
         end else if (bus.enable) begin
            if (div_cnt == DIV_LAST) begin
               div_cnt <= '0;
               tick_q  <= 1'b1;
               sec_q   <= sec_q + 8'd1;
            end else begin
               div_cnt <= div_cnt + DIV_W'(1);
            end
         end
      end
   end

   assign bus.tick      = tick_q;
   assign bus.sec_count = sec_q;
   assign bus.go        = go_q;
   assign bus.go_level  = level_q;

endmodule
`default_nettype wire

// File: tb/tb_sec_tick_go_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sec_tick_go_gen
//  Purpose  : Directed self-checking bench for sec_tick_go_gen with
//             CLK_DIV=5 and DB_CYCLES=4. Edge numbers in the comments count
//             rising edges after the point where the scenario starts.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sec_tick_go_gen;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   sec_tick_go_gen_if bus ();

   sec_tick_go_gen #(
      .CLK_DIV   (5),
      .DIV_W     (3),
      .DB_CYCLES (4),
      .DB_W      (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit past the last one
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold reset for two edges; the next edge after return is edge 1
   task automatic do_reset(input logic en);
      reset      = 1'b1;
      bus.go_raw = 1'b0;
      bus.enable = en;
      step(2);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset      = 1'b1;
      bus.enable = 1'b1;
      bus.go_raw = 1'b1;
      step(3);
      n_cmp++; if (bus.tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got=%b want=0", bus.tick); end
      n_cmp++; if (bus.sec_count !== 8'd0) begin n_err++; $display("FAIL reset_sec got=%0d want=0", bus.sec_count); end
      n_cmp++; if (bus.go !== 1'b0) begin n_err++; $display("FAIL reset_go got=%b want=0", bus.go); end
      n_cmp++; if (bus.go_level !== 1'b0) begin n_err++; $display("FAIL reset_level got=%b want=0", bus.go_level); end
   endtask

   // Ticks after edges 5, 10, 15 with sec_count 1, 2, 3
   task automatic test_tick;
      logic       et;
      logic [7:0] es;
      do_reset(1'b1);
      for (int e = 1; e <= 15; e++) begin
         step(1);
         et = (e % 5 == 0);
         es = 8'(e / 5);
         n_cmp++; if (bus.tick !== et) begin n_err++; $display("FAIL tick e=%0d got=%b want=%b", e, bus.tick, et); end
         n_cmp++; if (bus.sec_count !== es) begin n_err++; $display("FAIL tick_sec e=%0d got=%0d want=%0d", e, bus.sec_count, es); end
      end
   endtask

   // div_cnt=2 frozen for 7 cycles; 3 more enabled edges reach the tick
   task automatic test_enable;
      logic       et;
      logic [7:0] es;
      step(2);
      bus.enable = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         step(1);
         n_cmp++; if (bus.tick !== 1'b0) begin n_err++; $display("FAIL hold_tick i=%0d got=%b want=0", i, bus.tick); end
         n_cmp++; if (bus.sec_count !== 8'd3) begin n_err++; $display("FAIL hold_sec i=%0d got=%0d want=3", i, bus.sec_count); end
      end
      bus.enable = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step(1);
         et = (i == 3);
         es = (i == 3) ? 8'd4 : 8'd3;
         n_cmp++; if (bus.tick !== et) begin n_err++; $display("FAIL resume_tick i=%0d got=%b want=%b", i, bus.tick, et); end
         n_cmp++; if (bus.sec_count !== es) begin n_err++; $display("FAIL resume_sec i=%0d got=%0d want=%0d", i, bus.sec_count, es); end
      end
   endtask

   // Press sampled at edge 1 -> go after edge 6 only; go realigns timebase
   task automatic test_press;
      logic       eg;
      logic       el;
      logic       et;
      logic [7:0] es;
      bus.go_raw = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         step(1);
         eg = (e == 6);
         el = (e >= 6);
         et = (e == 5) || (e == 11) || (e == 16);
         es = (e < 5) ? 8'd4 : (e == 5) ? 8'd5 : (e <= 10) ? 8'd0 : (e <= 15) ? 8'd1 : 8'd2;
         n_cmp++; if (bus.go !== eg) begin n_err++; $display("FAIL press_go e=%0d got=%b want=%b", e, bus.go, eg); end
         n_cmp++; if (bus.go_level !== el) begin n_err++; $display("FAIL press_level e=%0d got=%b want=%b", e, bus.go_level, el); end
         n_cmp++; if (bus.tick !== et) begin n_err++; $display("FAIL press_tick e=%0d got=%b want=%b", e, bus.tick, et); end
         n_cmp++; if (bus.sec_count !== es) begin n_err++; $display("FAIL press_sec e=%0d got=%0d want=%0d", e, bus.sec_count, es); end
      end
      // Release: level falls after edge 6, no pulse
      bus.go_raw = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         step(1);
         el = (e < 6);
         n_cmp++; if (bus.go !== 1'b0) begin n_err++; $display("FAIL release_go e=%0d got=%b want=0", e, bus.go); end
         n_cmp++; if (bus.go_level !== el) begin n_err++; $display("FAIL release_level e=%0d got=%b want=%b", e, bus.go_level, el); end
      end
   endtask

   // Two-sample glitch is ignored completely
   task automatic test_glitch;
      bus.go_raw = 1'b1;
      step(2);
      bus.go_raw = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         step(1);
         n_cmp++; if (bus.go !== 1'b0) begin n_err++; $display("FAIL glitch_go e=%0d got=%b want=0", e, bus.go); end
         n_cmp++; if (bus.go_level !== 1'b0) begin n_err++; $display("FAIL glitch_level e=%0d got=%b want=0", e, bus.go_level); end
      end
   endtask

   // Press sampled at edge 5 -> go on edge 10, which is also a terminal
   // count: go wins, and the next tick lands on edge 15
   task automatic test_coincide;
      logic       eg;
      logic       et;
      logic [7:0] es;
      do_reset(1'b1);
      for (int e = 1; e <= 15; e++) begin
         step(1);
         eg = (e == 10);
         et = (e == 5) || (e == 15);
         es = (e < 5) ? 8'd0 : (e < 10) ? 8'd1 : (e < 15) ? 8'd0 : 8'd1;
         n_cmp++; if (bus.go !== eg) begin n_err++; $display("FAIL coin_go e=%0d got=%b want=%b", e, bus.go, eg); end
         n_cmp++; if (bus.tick !== et) begin n_err++; $display("FAIL coin_tick e=%0d got=%b want=%b", e, bus.tick, et); end
         n_cmp++; if (bus.sec_count !== es) begin n_err++; $display("FAIL coin_sec e=%0d got=%0d want=%0d", e, bus.sec_count, es); end
         if (e == 4) bus.go_raw = 1'b1;
      end
   endtask

   // Reset pulse while in PRESS_CHK (and on a terminal count) with sec=7
   task automatic test_reset_mid;
      logic       eg;
      logic       et;
      logic [7:0] es;
      do_reset(1'b1);
      step(35);
      n_cmp++; if (bus.sec_count !== 8'd7) begin n_err++; $display("FAIL mid_pre_sec got=%0d want=7", bus.sec_count); end
      bus.go_raw = 1'b1;
      step(4);
      reset = 1'b1;
      step(1);
      n_cmp++; if (bus.tick !== 1'b0) begin n_err++; $display("FAIL mid_tick got=%b want=0", bus.tick); end
      n_cmp++; if (bus.sec_count !== 8'd0) begin n_err++; $display("FAIL mid_sec got=%0d want=0", bus.sec_count); end
      n_cmp++; if (bus.go !== 1'b0) begin n_err++; $display("FAIL mid_go got=%b want=0", bus.go); end
      n_cmp++; if (bus.go_level !== 1'b0) begin n_err++; $display("FAIL mid_level got=%b want=0", bus.go_level); end
      reset = 1'b0;
      // Button still held: full debounce again, go after edge 6
      for (int e = 1; e <= 6; e++) begin
         step(1);
         eg = (e == 6);
         et = (e == 5);
         es = (e == 5) ? 8'd1 : 8'd0;
         n_cmp++; if (bus.go !== eg) begin n_err++; $display("FAIL repress_go e=%0d got=%b want=%b", e, bus.go, eg); end
         n_cmp++; if (bus.go_level !== eg) begin n_err++; $display("FAIL repress_level e=%0d got=%b want=%b", e, bus.go_level, eg); end
         n_cmp++; if (bus.tick !== et) begin n_err++; $display("FAIL repress_tick e=%0d got=%b want=%b", e, bus.tick, et); end
         n_cmp++; if (bus.sec_count !== es) begin n_err++; $display("FAIL repress_sec e=%0d got=%0d want=%0d", e, bus.sec_count, es); end
      end
   endtask

   // 256 ticks wrap sec_count to 0 silently
   task automatic test_wrap;
      do_reset(1'b1);
      step(1275);
      n_cmp++; if (bus.sec_count !== 8'd255) begin n_err++; $display("FAIL wrap_255 got=%0d want=255", bus.sec_count); end
      n_cmp++; if (bus.tick !== 1'b1) begin n_err++; $display("FAIL wrap_tick255 got=%b want=1", bus.tick); end
      step(5);
      n_cmp++; if (bus.sec_count !== 8'd0) begin n_err++; $display("FAIL wrap_0 got=%0d want=0", bus.sec_count); end
      n_cmp++; if (bus.tick !== 1'b1) begin n_err++; $display("FAIL wrap_tick0 got=%b want=1", bus.tick); end
      step(1);
      n_cmp++; if (bus.tick !== 1'b0) begin n_err++; $display("FAIL wrap_after got=%b want=0", bus.tick); end
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      reset      = 1'b1;
      bus.enable = 1'b0;
      bus.go_raw = 1'b0;
      test_reset;
      test_tick;
      test_enable;
      test_press;
      test_glitch;
      test_coincide;
      test_reset_mid;
      test_wrap;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
